io_port_responder: RTL

//   Device-side end of the CPU I/O handshake. Answers the CPU's input requests
//   (inp_req/inp_ack/inp_data) from an input FIFO filled by a host/peripheral.

---
 rtl/io_port_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/io_port_responder.sv
// Device side of the CPU I/O handshake: the input FIFO feeds CPU reads and the output FIFO absorbs CPU writes.
// Each channel has a req/ack FSM and a FIFO; the host works on the opposite end of each FIFO.
//
// state      | meaning
// S_IDLE     | waiting for req with FIFO ready
// S_ACK      | ack pulse this cycle
// S_WAIT_LOW | holding until req drops
module io_port_responder #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          inp_req,
  output logic          inp_ack,
  output logic [DW-1:0] inp_data,
  input  logic          out_req,
  input  logic [DW-1:0] out_data,
  output logic          out_ack,
  input  logic          host_wr_en,
  input  logic [DW-1:0] host_wr_data,
  output logic          host_in_full,
  input  logic          host_rd_en,
  output logic [DW-1:0] host_rd_data,
  output logic          host_rd_valid,
  output logic          host_out_empty,
  output logic [AW:0]   in_count,
  output logic [AW:0]   out_count,
  output logic [1:0]    err_flags
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_LOW} state_t;

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  state_t r_in_state, w_in_next;
  state_t r_out_state, w_out_next;

  logic [DW-1:0] r_in_mem  [DEPTH];
  logic [DW-1:0] r_out_mem [DEPTH];
  logic [AW-1:0] r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [AW:0]   r_in_cnt, r_out_cnt;
  logic [DW-1:0] r_inp_data, r_host_rd_data;
  logic          r_host_rd_valid;
  logic [1:0]    r_err;

  logic w_in_push, w_in_pop, w_out_push, w_out_pop;

  // Fullness and emptiness are judged on the counts before the clock edge.
  // Because of that, a word pushed this cycle cannot also be popped this cycle.
  assign w_in_push  = host_wr_en && (r_in_cnt != L_FULL);
  assign w_in_pop   = (r_in_state == S_IDLE) && inp_req && (r_in_cnt != '0);
  assign w_out_push = (r_out_state == S_IDLE) && out_req && (r_out_cnt != L_FULL);
  assign w_out_pop  = host_rd_en && (r_out_cnt != '0);

  always_comb begin
    w_in_next = r_in_state;
    case (r_in_state)
      S_IDLE:     if (w_in_pop) w_in_next = S_ACK;
      S_ACK:      w_in_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!inp_req) w_in_next = S_IDLE;
      default:    w_in_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_next = r_out_state;
    case (r_out_state)
      S_IDLE:     if (w_out_push) w_out_next = S_ACK;
      S_ACK:      w_out_next = S_WAIT_LOW;
      S_WAIT_LOW: if (!out_req) w_out_next = S_IDLE;
      default:    w_out_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_in_state  <= S_IDLE;
      r_out_state <= S_IDLE;
    end else begin
      r_in_state  <= w_in_next;
      r_out_state <= w_out_next;
    end
  end

  // The storage arrays are not reset; the pointers and counts define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wp]   <= host_wr_data;
    if (w_out_push) r_out_mem[r_out_wp] <= out_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_in_wp         <= '0;
      r_in_rp         <= '0;
      r_in_cnt        <= '0;
      r_out_wp        <= '0;
      r_out_rp        <= '0;
      r_out_cnt       <= '0;
      r_inp_data      <= '0;
      r_host_rd_data  <= '0;
      r_host_rd_valid <= 1'b0;
      r_err           <= 2'b00;
    end else begin
      if (w_in_push) r_in_wp <= r_in_wp + 1'b1;
      if (w_in_pop) begin
        r_in_rp    <= r_in_rp + 1'b1;
        r_inp_data <= r_in_mem[r_in_rp];
      end
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
        2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
        default: r_in_cnt <= r_in_cnt;
      endcase

      if (w_out_push) r_out_wp <= r_out_wp + 1'b1;
      if (w_out_pop) begin
        r_out_rp       <= r_out_rp + 1'b1;
        r_host_rd_data <= r_out_mem[r_out_rp];
      end
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase

      r_host_rd_valid <= w_out_pop;
      if (host_wr_en && (r_in_cnt == L_FULL)) r_err[1] <= 1'b1;
      if (host_rd_en && (r_out_cnt == '0))    r_err[0] <= 1'b1;
    end
  end

  assign inp_ack        = (r_in_state == S_ACK);
  assign out_ack        = (r_out_state == S_ACK);
  assign inp_data       = r_inp_data;
  assign host_rd_data   = r_host_rd_data;
  assign host_rd_valid  = r_host_rd_valid;
  assign host_in_full   = (r_in_cnt == L_FULL);
  assign host_out_empty = (r_out_cnt == '0);
  assign in_count       = r_in_cnt;
  assign out_count      = r_out_cnt;
  assign err_flags      = r_err;

endmodule
